// File: rtl/mc_sequencer_pkg.sv
// Shared types and encodings for the multicycle control sequencer.
package mc_pkg;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StRwb     = 4'd4,
    StMemAddr = 4'd5,
    StMemRd   = 4'd6,
    StMwb     = 4'd7,
    StMemWr   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StHalt    = 4'd11,
    StErr     = 4'd12
  } state_e;

  localparam logic [3:0] OPC_LW   = 4'b1000;
  localparam logic [3:0] OPC_SW   = 4'b1001;
  localparam logic [3:0] OPC_J    = 4'b1100;
  localparam logic [3:0] OPC_BEQ  = 4'b1101;
  localparam logic [3:0] OPC_HALT = 4'b1111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALU_B_REG = 2'b00;
  localparam logic [1:0] ALU_B_ONE = 2'b01;
  localparam logic [1:0] ALU_B_IMM = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

  // Control strobes that are valid for the whole time the FSM sits in a state.
  function automatic ctrl_t decode_ctrl(state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch:   c.mem_read = 1'b1;
      StExecR:   begin c.alu_src_a = 1'b1; c.alu_src_b = ALU_B_REG; c.alu_op = ALU_OP_FUNCT; end
      StRwb:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      StMemAddr: begin c.alu_src_a = 1'b1; c.alu_src_b = ALU_B_IMM; c.alu_op = ALU_OP_ADD; end
      StMemRd:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
      StMwb:     begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      StMemWr:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
      StBranch:  begin c.alu_src_a = 1'b1; c.alu_src_b = ALU_B_REG; c.alu_op = ALU_OP_SUB; end
      StHalt:    c.halted = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Sequencer-to-datapath/memory bundle; master is the sequencer side.
interface mc_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
);
  logic              run;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              alu_zero;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic              mem_read;
  logic              mem_write;
  logic              iord;
  logic              ir_write;
  logic              reg_write;
  logic              reg_dst;
  logic              mem_to_reg;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic [1:0]        alu_op;
  logic [3:0]        state_dbg;
  logic              halted;
  logic              err_timeout;

  modport master (
    input  run, mem_rdata, mem_ready, alu_zero,
    output pc, ir, mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, state_dbg, halted, err_timeout
  );

  modport slave (
    output run, mem_rdata, mem_ready, alu_zero,
    input  pc, ir, mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, state_dbg, halted, err_timeout
  );
endinterface

// File: rtl/mc_sequencer_wait_timer.sv
// Memory wait-state counter: counts stalled cycles, flags the last allowed one without ready.
module mc_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic ready,
  output logic expired
);
  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = (clear || ready) ? '0 : count_q + 1'b1;
    // This cycle brings the count to WAIT_MAX; a ready here still wins.
    expired = !clear && !ready && (count_q == CNT_W'(WAIT_MAX - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end
endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer: PC/IR ownership, control FSM, registered datapath strobes.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned OPC_W    = 4,
  parameter int unsigned WAIT_MAX = 15
) (
  input logic            clock,
  input logic            reset,
  mc_sequencer_if.master bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  ctrl_t             ctrl_q;
  logic              ir_write_q, ir_load;
  logic              err_q;
  logic              run_q;
  logic              mem_state, expired;
  logic [3:0]        opc;
  logic [ADDR_W-1:0] br_off;

  assign opc       = 4'(ir_q[DATA_W-1 -: OPC_W]);
  assign br_off    = {{(ADDR_W - 4){ir_q[3]}}, ir_q[3:0]};
  assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

  mc_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!mem_state),
    .ready  (bus.mem_ready),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_load = 1'b0;
    unique case (state_q)
      StIdle: if (bus.run) state_d = StFetch;
      StFetch: begin
        if (bus.mem_ready) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc_q + 1'b1;
          ir_load = 1'b1;
          state_d = StDecode;
        end else if (expired) begin
          state_d = StErr;
        end
      end
      StDecode: begin
        if (!opc[3]) begin
          state_d = StExecR;
        end else begin
          case (opc)
            OPC_LW, OPC_SW: state_d = StMemAddr;
            OPC_J:          state_d = StJump;
            OPC_BEQ:        state_d = StBranch;
            OPC_HALT:       state_d = StHalt;
            default:        state_d = StFetch;
          endcase
        end
      end
      StExecR:   state_d = StRwb;
      StRwb:     state_d = StFetch;
      StMemAddr: state_d = (opc == OPC_LW) ? StMemRd : StMemWr;
      StMemRd: begin
        if (bus.mem_ready) state_d = StMwb;
        else if (expired)  state_d = StErr;
      end
      StMwb: state_d = StFetch;
      StMemWr: begin
        if (bus.mem_ready) state_d = StFetch;
        else if (expired)  state_d = StErr;
      end
      StBranch: begin
        // pc already points past the branch, so the offset is relative to pc+1.
        if (bus.alu_zero) pc_d = pc_q + br_off;
        state_d = StFetch;
      end
      StJump: begin
        pc_d    = ir_q[ADDR_W-1:0];
        state_d = StFetch;
      end
      StHalt: if (bus.run && !run_q) state_d = StFetch;
      StErr:  state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      ir_q       <= '0;
      ctrl_q     <= '0;
      ir_write_q <= 1'b0;
      err_q      <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ctrl_q     <= decode_ctrl(state_d);
      ir_write_q <= ir_load;
      err_q      <= err_q || (state_d == StErr);
      run_q      <= bus.run;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.ir          = ir_q;
  assign bus.mem_read    = ctrl_q.mem_read;
  assign bus.mem_write   = ctrl_q.mem_write;
  assign bus.iord        = ctrl_q.iord;
  assign bus.ir_write    = ir_write_q;
  assign bus.reg_write   = ctrl_q.reg_write;
  assign bus.reg_dst     = ctrl_q.reg_dst;
  assign bus.mem_to_reg  = ctrl_q.mem_to_reg;
  assign bus.alu_src_a   = ctrl_q.alu_src_a;
  assign bus.alu_src_b   = ctrl_q.alu_src_b;
  assign bus.alu_op      = ctrl_q.alu_op;
  assign bus.state_dbg   = state_q;
  assign bus.halted      = ctrl_q.halted;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: directed scenarios plus a randomized program against an
// instruction-level model.
module tb_mc_sequencer;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned WAIT_MAX = 15;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3;
  localparam logic [3:0] S_RWB = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MWB = 4'd7;
  localparam logic [3:0] S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_HALT = 4'd11;
  localparam logic [3:0] S_ERR = 4'd12;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  mc_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mc_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(4), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // {mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, halted}
  function automatic logic [11:0] exp_ctl(input logic [3:0] s);
    case (s)
      S_FETCH:    return 12'b1000000_00_00_0;
      S_EXEC_R:   return 12'b0000001_00_10_0;
      S_RWB:      return 12'b0001100_00_00_0;
      S_MEM_ADDR: return 12'b0000001_10_00_0;
      S_MEM_RD:   return 12'b1010000_00_00_0;
      S_MWB:      return 12'b0001010_00_00_0;
      S_MEM_WR:   return 12'b0110000_00_00_0;
      S_BRANCH:   return 12'b0000001_00_01_0;
      S_HALT:     return 12'b0000000_00_00_1;
      default:    return 12'b0;
    endcase
  endfunction

  function automatic logic [11:0] obs_ctl();
    return {bus.mem_read, bus.mem_write, bus.iord, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.halted};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [15:0] rd, input logic z);
    bus.mem_ready = rdy;
    bus.mem_rdata = rd;
    bus.alu_zero  = z;
  endtask

  // Assumes FETCH; runs a J instruction to addr with no checking.
  task automatic jump_to(input logic [5:0] addr);
    drive(1'b1, {4'hC, 6'd0, addr}, 1'b0); tick();
    drive(1'b0, 16'h0, 1'b0); tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.run = 1'b0; drive(1'b0, 16'h0, 1'b0);
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.state_dbg !== S_IDLE) begin errors++;
      $display("FAIL reset_state got %0d want %0d", bus.state_dbg, S_IDLE); end
    checks++; if ({bus.pc, bus.ir} !== 22'h0) begin errors++;
      $display("FAIL reset_pc_ir got pc=%0d ir=%h want 0/0", bus.pc, bus.ir); end
    checks++; if ({obs_ctl(), bus.ir_write, bus.err_timeout} !== 14'h0) begin errors++;
      $display("FAIL reset_strobes got %b want 0", {obs_ctl(), bus.ir_write, bus.err_timeout}); end
    drive(1'b1, 16'hFFFF, 1'b1); tick();
    checks++; if (bus.state_dbg !== S_IDLE || bus.pc !== 6'd0) begin errors++;
      $display("FAIL idle_ignores_ready got st=%0d pc=%0d want 0/0", bus.state_dbg, bus.pc); end
  endtask

  task automatic test_fetch_rtype();
    bus.run = 1'b1; drive(1'b1, 16'h0123, 1'b0); tick();
    checks++; if (bus.state_dbg !== S_FETCH || obs_ctl() !== exp_ctl(S_FETCH)) begin errors++;
      $display("FAIL fetch_entry got st=%0d ctl=%b want %0d/%b", bus.state_dbg, obs_ctl(),
               S_FETCH, exp_ctl(S_FETCH)); end
    tick();
    checks++; if ({bus.state_dbg, bus.ir, bus.pc, bus.ir_write} !== {S_DECODE, 16'h0123, 6'd1, 1'b1})
    begin errors++;
      $display("FAIL fetch_capture got st=%0d ir=%h pc=%0d irw=%b want 2/0123/1/1",
               bus.state_dbg, bus.ir, bus.pc, bus.ir_write); end
    drive(1'b0, 16'h0, 1'b0); tick();
    checks++; if (bus.state_dbg !== S_EXEC_R || obs_ctl() !== exp_ctl(S_EXEC_R)) begin errors++;
      $display("FAIL exec_r got st=%0d ctl=%b", bus.state_dbg, obs_ctl()); end
    tick();
    checks++; if (bus.state_dbg !== S_RWB || obs_ctl() !== exp_ctl(S_RWB)) begin errors++;
      $display("FAIL rwb got st=%0d ctl=%b want %b", bus.state_dbg, obs_ctl(), exp_ctl(S_RWB)); end
    tick();
    checks++; if (bus.state_dbg !== S_FETCH || bus.reg_write !== 1'b0) begin errors++;
      $display("FAIL rwb_one_cycle got st=%0d rw=%b want 1/0", bus.state_dbg, bus.reg_write); end
  endtask

  task automatic test_lw_wait();
    drive(1'b1, 16'h8A12, 1'b0); tick();
    drive(1'b0, 16'h0, 1'b0); tick();
    checks++; if (bus.state_dbg !== S_MEM_ADDR || obs_ctl() !== exp_ctl(S_MEM_ADDR)) begin errors++;
      $display("FAIL lw_mem_addr got st=%0d ctl=%b", bus.state_dbg, obs_ctl()); end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus.state_dbg, bus.mem_read, bus.iord} !== {S_MEM_RD, 2'b11}) begin errors++;
        $display("FAIL lw_wait_%0d got st=%0d rd=%b iord=%b want 6/1/1", i, bus.state_dbg,
                 bus.mem_read, bus.iord); end
      drive(i == 3, 16'h5555, 1'b0); tick();
    end
    checks++; if (bus.state_dbg !== S_MWB || obs_ctl() !== exp_ctl(S_MWB)) begin errors++;
      $display("FAIL lw_mwb got st=%0d ctl=%b want %b", bus.state_dbg, obs_ctl(), exp_ctl(S_MWB)); end
    drive(1'b0, 16'h0, 1'b0); tick();
    checks++; if (bus.state_dbg !== S_FETCH || bus.pc !== 6'd2) begin errors++;
      $display("FAIL lw_done got st=%0d pc=%0d want 1/2", bus.state_dbg, bus.pc); end
  endtask

  task automatic test_branch();
    for (int z = 1; z >= 0; z--) begin
      jump_to(6'd5);
      checks++; if (bus.state_dbg !== S_FETCH || bus.pc !== 6'd5) begin errors++;
        $display("FAIL jump_to5 got st=%0d pc=%0d want 1/5", bus.state_dbg, bus.pc); end
      drive(1'b1, 16'hD00E, 1'b0); tick();
      drive(1'b0, 16'h0, z[0]); tick();
      checks++; if (bus.state_dbg !== S_BRANCH || obs_ctl() !== exp_ctl(S_BRANCH)) begin errors++;
        $display("FAIL beq_state got st=%0d ctl=%b", bus.state_dbg, obs_ctl()); end
      tick();
      checks++; if (bus.pc !== (z ? 6'd4 : 6'd6) || bus.state_dbg !== S_FETCH) begin errors++;
        $display("FAIL beq_z%0d_pc got pc=%0d st=%0d want %0d/1", z, bus.pc, bus.state_dbg,
                 z ? 4 : 6); end
    end
  endtask

  task automatic test_jump_wrap();
    drive(1'b1, 16'hC03F, 1'b0); tick();
    drive(1'b0, 16'h0, 1'b0); tick();
    checks++; if (bus.state_dbg !== S_JUMP) begin errors++;
      $display("FAIL jump_state got %0d want %0d", bus.state_dbg, S_JUMP); end
    tick();
    checks++; if (bus.pc !== 6'd63) begin errors++;
      $display("FAIL jump_pc got %0d want 63", bus.pc); end
    drive(1'b1, 16'h0000, 1'b0); tick();
    checks++; if (bus.pc !== 6'd0 || bus.state_dbg !== S_DECODE) begin errors++;
      $display("FAIL pc_wrap got pc=%0d st=%0d want 0/2", bus.pc, bus.state_dbg); end
    drive(1'b0, 16'h0, 1'b0); tick(); tick(); tick();
  endtask

  task automatic test_timeout();
    // Ready on the last permitted wait cycle still succeeds.
    for (int i = 0; i < 15; i++) begin
      checks++; if (bus.state_dbg !== S_FETCH) begin errors++;
        $display("FAIL late_ready_wait_%0d got st=%0d want 1", i, bus.state_dbg); end
      drive(i == 14, 16'hA000, 1'b0); tick();
    end
    checks++; if (bus.state_dbg !== S_DECODE || bus.err_timeout !== 1'b0) begin errors++;
      $display("FAIL late_ready got st=%0d err=%b want 2/0", bus.state_dbg, bus.err_timeout); end
    drive(1'b0, 16'h0, 1'b0); tick();
    for (int i = 0; i < 15; i++) begin
      checks++; if (bus.state_dbg !== S_FETCH) begin errors++;
        $display("FAIL timeout_wait_%0d got st=%0d want 1", i, bus.state_dbg); end
      drive(1'b0, 16'($urandom), 1'b0); tick();
    end
    checks++; if ({bus.state_dbg, bus.err_timeout, obs_ctl()} !== {S_ERR, 1'b1, 12'h0}) begin
      errors++;
      $display("FAIL timeout_err got st=%0d err=%b ctl=%b want 12/1/0", bus.state_dbg,
               bus.err_timeout, obs_ctl()); end
    bus.run = 1'b0; drive(1'b1, 16'h0123, 1'b0); tick();
    bus.run = 1'b1; tick(); tick();
    checks++; if (bus.state_dbg !== S_ERR || bus.err_timeout !== 1'b1) begin errors++;
      $display("FAIL err_sticky got st=%0d err=%b want 12/1", bus.state_dbg, bus.err_timeout); end
    bus.run = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    checks++; if ({bus.state_dbg, bus.err_timeout, bus.pc} !== {S_IDLE, 1'b0, 6'd0}) begin errors++;
      $display("FAIL err_reset got st=%0d err=%b pc=%0d want 0/0/0", bus.state_dbg,
               bus.err_timeout, bus.pc); end
  endtask

  task automatic test_halt();
    bus.run = 1'b1; drive(1'b0, 16'h0, 1'b0); tick();
    drive(1'b1, 16'hF000, 1'b0); tick();
    drive(1'b0, 16'h0, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      checks++; if ({bus.state_dbg, bus.halted, bus.pc} !== {S_HALT, 1'b1, 6'd1}) begin errors++;
        $display("FAIL halt_hold_%0d got st=%0d halted=%b pc=%0d want 11/1/1", i, bus.state_dbg,
                 bus.halted, bus.pc); end
      drive($urandom_range(0, 1), 16'($urandom), 1'b0); tick();
    end
    bus.run = 1'b0; tick();
    checks++; if (bus.state_dbg !== S_HALT) begin errors++;
      $display("FAIL halt_run_low got st=%0d want 11", bus.state_dbg); end
    bus.run = 1'b1; tick();
    checks++; if (bus.state_dbg !== S_FETCH || bus.halted !== 1'b0) begin errors++;
      $display("FAIL halt_resume got st=%0d halted=%b want 1/0", bus.state_dbg, bus.halted); end
  endtask

  task automatic test_reset_mid_write();
    drive(1'b1, 16'h9000, 1'b0); tick();
    drive(1'b0, 16'h0, 1'b0); tick(); tick();
    checks++; if (bus.state_dbg !== S_MEM_WR || obs_ctl() !== exp_ctl(S_MEM_WR)) begin errors++;
      $display("FAIL sw_mem_wr got st=%0d ctl=%b", bus.state_dbg, obs_ctl()); end
    tick();
    reset = 1'b1; tick(); reset = 1'b0; bus.run = 1'b0;
    checks++; if ({bus.state_dbg, bus.mem_write, bus.pc} !== {S_IDLE, 1'b0, 6'd0}) begin errors++;
      $display("FAIL reset_mid_write got st=%0d mw=%b pc=%0d want 0/0/0", bus.state_dbg,
               bus.mem_write, bus.pc); end
  endtask

  // Instruction-level model: path of states per opcode, pc via integer arithmetic.
  task automatic test_random_program();
    int          m_pc;
    int          off;
    int          lat;
    int          cycles;
    logic [3:0]  opc;
    logic [15:0] word;
    logic        z;
    logic [3:0]  s;
    logic [3:0]  path[$];
    bus.run = 1'b1; drive(1'b0, 16'h0, 1'b0); tick();
    m_pc = 0;
    for (int n = 0; n < 80; n++) begin
      opc  = 4'($urandom_range(0, 14));
      word = {opc, 12'($urandom)};
      lat  = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 4);
      z    = 1'($urandom);
      path = {S_FETCH, S_DECODE};
      if (opc < 4'd8)        begin path.push_back(S_EXEC_R); path.push_back(S_RWB); end
      else if (opc == 4'd8)  begin path.push_back(S_MEM_ADDR); path.push_back(S_MEM_RD);
                                   path.push_back(S_MWB); end
      else if (opc == 4'd9)  begin path.push_back(S_MEM_ADDR); path.push_back(S_MEM_WR); end
      else if (opc == 4'd12) path.push_back(S_JUMP);
      else if (opc == 4'd13) path.push_back(S_BRANCH);
      m_pc = (m_pc + 1) % 64;
      if (opc == 4'd12) m_pc = int'(word) % 64;
      if (opc == 4'd13 && z) begin
        off  = int'(word[3:0]) - (word[3] ? 16 : 0);
        m_pc = (m_pc + off + 64) % 64;
      end
      foreach (path[k]) begin
        s      = path[k];
        cycles = (s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR) ? lat + 1 : 1;
        for (int c = 0; c < cycles; c++) begin
          checks++;
          if ({bus.state_dbg, obs_ctl(), bus.ir_write} !== {s, exp_ctl(s), s == S_DECODE}) begin
            errors++;
            $display("FAIL rand_%0d_step got st=%0d ctl=%b irw=%b want %0d/%b/%b", n,
                     bus.state_dbg, obs_ctl(), bus.ir_write, s, exp_ctl(s), s == S_DECODE);
          end
          if (cycles > 1 || s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR)
            drive(c == cycles - 1, (s == S_FETCH && c == cycles - 1) ? word : 16'($urandom), z);
          else
            drive(1'($urandom), 16'($urandom), z);
          bus.run = 1'($urandom);
          tick();
        end
      end
      checks++; if (bus.pc !== 6'(m_pc) || bus.ir !== word) begin errors++;
        $display("FAIL rand_%0d_arch instr=%h got pc=%0d ir=%h want pc=%0d", n, word, bus.pc,
                 bus.ir, m_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_rtype();
    test_lw_wait();
    test_branch();
    test_jump_wrap();
    test_timeout();
    test_halt();
    test_reset_mid_write();
    test_random_program();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end
endmodule
